// File: rtl/mem_pipe_pkg.sv
// Shared types for the EXE->MEM pipeline register: field width defaults,
// the packed instruction payload and the skid-buffer occupancy states.
package mem_pipe_pkg;

   localparam int PC_W_DEFAULT   = 32;
   localparam int DATA_W_DEFAULT = 32;
   localparam int DEST_W_DEFAULT = 5;

   typedef struct packed {
      logic [PC_W_DEFAULT-1:0]   pc;
      logic [DATA_W_DEFAULT-1:0] alu_result;
      logic [DATA_W_DEFAULT-1:0] reg2;
      logic [DEST_W_DEFAULT-1:0] dest;
      logic                      wb_en;
      logic                      mem_read;
      logic                      mem_write;
   } mem_payload_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/exe_mem_skid_reg_if.sv
// EXE->MEM boundary bundle. The slave modport is the pipeline register; the
// master modport is whatever drives EXE-side inputs and observes MEM-side outputs.
interface exe_mem_skid_reg_if
   import mem_pipe_pkg::*;
#(
   parameter int PC_W   = PC_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DEST_W = DEST_W_DEFAULT
);

   // Handshake: a transfer into the register happens on a clock edge where
   // in_valid & in_ready are both 1; in_ready is a flop, never derived from
   // freeze in the same cycle. The held entry leaves when out_valid & ~freeze.
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   pc_in;
   logic [DATA_W-1:0] alu_result_in;
   logic [DATA_W-1:0] reg2_in;
   logic [DEST_W-1:0] dest_in;
   logic              wb_en_in;
   logic              mem_read_in;
   logic              mem_write_in;
   logic              flush;
   logic              freeze;
   logic              out_valid;
   logic [PC_W-1:0]   pc_out;
   logic [DATA_W-1:0] alu_result_out;
   logic [DATA_W-1:0] reg2_out;
   logic [DEST_W-1:0] dest_out;
   logic              wb_en_out;
   logic              mem_read_out;
   logic              mem_write_out;
   skid_state_t       state;

   modport master (
      output in_valid, pc_in, alu_result_in, reg2_in, dest_in,
             wb_en_in, mem_read_in, mem_write_in, flush, freeze,
      input  in_ready, out_valid, pc_out, alu_result_out, reg2_out, dest_out,
             wb_en_out, mem_read_out, mem_write_out, state
   );

   modport slave (
      input  in_valid, pc_in, alu_result_in, reg2_in, dest_in,
             wb_en_in, mem_read_in, mem_write_in, flush, freeze,
      output in_ready, out_valid, pc_out, alu_result_out, reg2_out, dest_out,
             wb_en_out, mem_read_out, mem_write_out, state
   );

endinterface

// File: rtl/payload_reg.sv
// Instruction payload register with load enable and async active-low clear.
// Used twice in the pipeline register: once as main, once as skid.
module payload_reg
   import mem_pipe_pkg::*;
#(
   parameter type payload_t = mem_payload_t
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     load,
   input  payload_t d,
   output payload_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    q <= '0;
      else if (load) q <= d;
   end

endmodule

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a 2-entry skid so MEM freeze never reaches
// EXE combinationally. Optional perf counters under `EXE_MEM_PERF_EN.
module exe_mem_skid_reg
   import mem_pipe_pkg::*;
#(
   parameter int PC_W   = PC_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DEST_W = DEST_W_DEFAULT
) (
   input  logic               clk,
   input  logic               rst,
   exe_mem_skid_reg_if.slave  bus
`ifdef EXE_MEM_PERF_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [31:0]        bubble_cycles,
   output logic [15:0]        skid_hits
`endif
);

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] reg2;
      logic [DEST_W-1:0] dest;
      logic              wb_en;
      logic              mem_read;
      logic              mem_write;
   } payload_t;

   skid_state_t state;
   logic        in_ready_q;
   logic        out_valid;
   logic        accept;
   logic        consume;
   logic        main_load;
   logic        skid_load;
   payload_t    in_pl;
   payload_t    main_d;
   payload_t    main_q;
   payload_t    skid_q;

   assign out_valid = (state != EMPTY);
   assign accept    = bus.in_valid & in_ready_q;
   assign consume   = out_valid & ~bus.freeze;

   assign in_pl = '{pc: bus.pc_in, alu_result: bus.alu_result_in, reg2: bus.reg2_in,
                    dest: bus.dest_in, wb_en: bus.wb_en_in, mem_read: bus.mem_read_in,
                    mem_write: bus.mem_write_in};

   // Main only loads when empty or being consumed, so it is frozen with freeze.
   always_comb begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_d    = in_pl;
      if (!bus.flush) begin
         case (state)
            EMPTY: main_load = accept;
            BUSY: begin
               main_load = accept & consume;
               skid_load = accept & ~consume;
            end
            FULL: begin
               main_load = consume;
               main_d    = skid_q;
            end
            default: ;
         endcase
      end
   end

   payload_reg #(.payload_t(payload_t)) u_main (
      .clk(clk), .rst_n(rst), .load(main_load), .d(main_d), .q(main_q)
   );

   payload_reg #(.payload_t(payload_t)) u_skid (
      .clk(clk), .rst_n(rst), .load(skid_load), .d(in_pl), .q(skid_q)
   );

   // in_ready_q tracks "next state is not FULL" so EXE stalls from a flop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= EMPTY;
         in_ready_q <= 1'b1;
      end else if (bus.flush) begin
         state      <= (out_valid & bus.freeze) ? BUSY : EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) state <= BUSY;
               in_ready_q <= 1'b1;
            end
            BUSY: begin
               if (accept & ~consume) begin
                  state      <= FULL;
                  in_ready_q <= 1'b0;
               end else if (~accept & consume) begin
                  state <= EMPTY;
               end
            end
            FULL: begin
               if (consume) begin
                  state      <= BUSY;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state      <= EMPTY;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.state          = state;
   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid;
   assign bus.pc_out         = main_q.pc;
   assign bus.alu_result_out = main_q.alu_result;
   assign bus.reg2_out       = main_q.reg2;
   assign bus.dest_out       = main_q.dest;
   assign bus.wb_en_out      = main_q.wb_en & out_valid;
   assign bus.mem_read_out   = main_q.mem_read & out_valid;
   assign bus.mem_write_out  = main_q.mem_write & out_valid;

`ifdef EXE_MEM_PERF_EN
   // Saturating counters; only rst clears them, flush does not.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles  <= '0;
         bubble_cycles <= '0;
         skid_hits     <= '0;
      end else begin
         if (out_valid && bus.freeze && !(&stall_cycles))
            stall_cycles <= stall_cycles + 32'd1;
         if (!out_valid && !(&bubble_cycles))
            bubble_cycles <= bubble_cycles + 32'd1;
         if (skid_load && !(&skid_hits))
            skid_hits <= skid_hits + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Self-checking bench for exe_mem_skid_reg: directed scenarios plus random
// traffic against a queue model of the buffer contents.
module tb_exe_mem_skid_reg;
   import mem_pipe_pkg::*;

   localparam int PW = $bits(mem_payload_t);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   exe_mem_skid_reg_if bus ();

`ifdef EXE_MEM_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] bubble_cycles;
   logic [15:0] skid_hits;
`endif

   exe_mem_skid_reg dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef EXE_MEM_PERF_EN
      ,
      .stall_cycles(stall_cycles),
      .bubble_cycles(bubble_cycles),
      .skid_hits(skid_hits)
`endif
   );

   // ---------------- scoreboard / reference model ----------------
   logic [PW-1:0] exp_q[$];
   bit            exp_ready;
   int            exp_stall, exp_bubble, exp_skid;
   int            checks = 0;
   int            errors = 0;

   function automatic mem_payload_t mk(input logic [31:0] pc, input logic [31:0] alu,
                                       input logic [31:0] r2, input logic [4:0] dst,
                                       input logic wb, input logic rd, input logic wr);
      mem_payload_t p;
      p.pc = pc; p.alu_result = alu; p.reg2 = r2; p.dest = dst;
      p.wb_en = wb; p.mem_read = rd; p.mem_write = wr;
      return p;
   endfunction

   function automatic mem_payload_t observed();
      mem_payload_t o;
      o.pc = bus.pc_out; o.alu_result = bus.alu_result_out; o.reg2 = bus.reg2_out;
      o.dest = bus.dest_out; o.wb_en = bus.wb_en_out; o.mem_read = bus.mem_read_out;
      o.mem_write = bus.mem_write_out;
      return o;
   endfunction

   function automatic skid_state_t exp_state();
      case (exp_q.size())
         0:       return EMPTY;
         1:       return BUSY;
         default: return FULL;
      endcase
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      exp_ready  = 1'b1;
      exp_stall  = 0;
      exp_bubble = 0;
      exp_skid   = 0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input bit v, input mem_payload_t p, input bit fl, input bit fz);
      bus.in_valid      = v;
      bus.pc_in         = p.pc;
      bus.alu_result_in = p.alu_result;
      bus.reg2_in       = p.reg2;
      bus.dest_in       = p.dest;
      bus.wb_en_in      = p.wb_en;
      bus.mem_read_in   = p.mem_read;
      bus.mem_write_in  = p.mem_write;
      bus.flush         = fl;
      bus.freeze        = fz;
   endtask

   task automatic idle(input bit fz);
      drive(1'b0, mk(0, 0, 0, 0, 0, 0, 0), 1'b0, fz);
   endtask

   // Advance the model with the inputs currently applied, then clock the DUT.
   task automatic tick();
      logic [PW-1:0] inp;
      int            sz;
      bit            acc, cons;
      inp  = {bus.pc_in, bus.alu_result_in, bus.reg2_in, bus.dest_in,
              bus.wb_en_in, bus.mem_read_in, bus.mem_write_in};
      sz   = exp_q.size();
      acc  = bus.in_valid && exp_ready;
      cons = (sz != 0) && !bus.freeze;
      if (sz != 0 && bus.freeze) exp_stall++;
      if (sz == 0) exp_bubble++;
      if (bus.flush) begin
         if (sz != 0 && bus.freeze) begin
            while (exp_q.size() > 1) void'(exp_q.pop_back());
         end else begin
            exp_q.delete();
         end
         exp_ready = 1'b1;
      end else begin
         if (cons) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(inp);
         exp_ready = (exp_q.size() < 2);
         if (sz == 1 && exp_q.size() == 2) exp_skid++;
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle(1'b0);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.state !== EMPTY) begin errors++; $display("FAIL reset_state got %0d exp EMPTY", bus.state); end
      checks++; if (observed() !== mem_payload_t'(0)) begin errors++; $display("FAIL reset_payload got %h exp 0", observed()); end
`ifdef EXE_MEM_PERF_EN
      checks++; if ({stall_cycles, bubble_cycles, skid_hits} !== 80'd0) begin errors++; $display("FAIL reset_perf got %0d/%0d/%0d exp 0", stall_cycles, bubble_cycles, skid_hits); end
`endif
      rst = 1'b1;
      model_reset();
   endtask

   task automatic test_steady_flow();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, mk(32'(i * 4), 32'h1000 + 32'(i), 32'(i), 5'(i + 1), 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
         tick();
         checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flow_in_ready i=%0d got %b exp 1", i, bus.in_ready); end
         checks++; if (bus.pc_out !== 32'(i * 4)) begin errors++; $display("FAIL flow_pc i=%0d got %h exp %h", i, bus.pc_out, i * 4); end
         checks++; if (bus.state === FULL) begin errors++; $display("FAIL flow_not_full i=%0d got FULL exp BUSY", i); end
      end
      idle(1'b0);
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flow_drain got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_freeze_skid();
      int s0, k0;
      drive(1'b1, mk(32'h10, 32'h100, 0, 5'd3, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
      tick();
      s0 = exp_stall;
      k0 = exp_skid;
      drive(1'b1, mk(32'h14, 32'h104, 32'hDEAD, 0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b1);
      tick();
      checks++; if (bus.state !== FULL) begin errors++; $display("FAIL skid_full got %0d exp FULL", bus.state); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL skid_in_ready got %b exp 0", bus.in_ready); end
      idle(1'b1);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus.alu_result_out !== 32'h100 || bus.pc_out !== 32'h10 || bus.mem_read_out !== 1'b1) begin
            errors++; $display("FAIL skid_main_stable i=%0d got pc %h addr %h exp pc 10 addr 100", i, bus.pc_out, bus.alu_result_out);
         end
         tick();
      end
      idle(1'b0);
      tick();
      checks++; if (bus.pc_out !== 32'h14 || bus.mem_write_out !== 1'b1) begin errors++; $display("FAIL skid_advance got pc %h exp 14", bus.pc_out); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL skid_ready_back got %b exp 1", bus.in_ready); end
      checks++; if (exp_stall - s0 != 5 || exp_skid - k0 != 1) begin errors++; $display("FAIL skid_model_counts got %0d/%0d exp 5/1", exp_stall - s0, exp_skid - k0); end
`ifdef EXE_MEM_PERF_EN
      checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL perf_stall got %0d exp %0d", stall_cycles, exp_stall); end
      checks++; if (skid_hits !== 16'(exp_skid)) begin errors++; $display("FAIL perf_skid got %0d exp %0d", skid_hits, exp_skid); end
      checks++; if (bubble_cycles !== 32'(exp_bubble)) begin errors++; $display("FAIL perf_bubble got %0d exp %0d", bubble_cycles, exp_bubble); end
`endif
      tick();
   endtask

   task automatic test_bubble_gating();
      drive(1'b0, mk(32'h40, 32'h200, 32'h5, 5'd7, 1'b1, 1'b1, 1'b1), 1'b0, 1'b0);
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.mem_write_out !== 1'b0 || bus.wb_en_out !== 1'b0 || bus.mem_read_out !== 1'b0) begin
         errors++; $display("FAIL bubble_ctrl got %b%b%b exp 000", bus.wb_en_out, bus.mem_read_out, bus.mem_write_out);
      end
   endtask

   task automatic test_flush_freeze_full();
      drive(1'b1, mk(32'h24, 32'h180, 0, 5'd9, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
      tick();
      drive(1'b1, mk(32'h28, 32'h184, 32'h77, 0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b1);
      tick();
      drive(1'b1, mk(32'h30, 32'h300, 0, 5'd1, 1'b1, 1'b0, 1'b0), 1'b1, 1'b1);
      tick();
      checks++; if (bus.state !== BUSY) begin errors++; $display("FAIL ffull_state got %0d exp BUSY", bus.state); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL ffull_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.pc_out !== 32'h24 || bus.mem_read_out !== 1'b1) begin errors++; $display("FAIL ffull_main_kept got pc %h exp 24", bus.pc_out); end
      idle(1'b0);
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ffull_after got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_flush_busy();
      drive(1'b1, mk(32'h1C, 32'h1C0, 0, 5'd2, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
      tick();
      drive(1'b1, mk(32'h20, 32'h220, 0, 5'd4, 1'b1, 1'b0, 1'b0), 1'b1, 1'b0);
      tick();
      checks++; if (bus.state !== EMPTY || bus.out_valid !== 1'b0) begin errors++; $display("FAIL fbusy_empty got state %0d valid %b exp EMPTY 0", bus.state, bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL fbusy_in_ready got %b exp 1", bus.in_ready); end
      idle(1'b0);
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fbusy_discard got %b pc %h exp 0", bus.out_valid, bus.pc_out); end
   endtask

   task automatic test_async_reset();
      drive(1'b1, mk(32'h50, 32'h500, 0, 5'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
      tick();
      drive(1'b1, mk(32'h54, 32'h504, 32'h9, 0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b1);
      tick();
      idle(1'b1);
      #3 rst = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL areset_in_ready got %b exp 1", bus.in_ready); end
      checks++; if (bus.state !== EMPTY || bus.mem_read_out !== 1'b0) begin errors++; $display("FAIL areset_state got %0d exp EMPTY", bus.state); end
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle(1'b0);
      model_reset();
   endtask

   task automatic test_random();
      mem_payload_t p;
      for (int c = 0; c < 400; c++) begin
         p = mk($urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         drive($urandom_range(0, 99) < 70, p, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 35);
         tick();
         checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, bus.out_valid, exp_q.size() != 0); end
         checks++; if (bus.in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready c=%0d got %b exp %b", c, bus.in_ready, exp_ready); end
         checks++; if (bus.state !== exp_state()) begin errors++; $display("FAIL rnd_state c=%0d got %0d exp %0d", c, bus.state, exp_state()); end
         checks++;
         if (exp_q.size() != 0) begin
            if (observed() !== mem_payload_t'(exp_q[0])) begin errors++; $display("FAIL rnd_payload c=%0d got %h exp %h", c, observed(), exp_q[0]); end
         end else if ({bus.wb_en_out, bus.mem_read_out, bus.mem_write_out} !== 3'b000) begin
            errors++; $display("FAIL rnd_gating c=%0d got %b exp 000", c, {bus.wb_en_out, bus.mem_read_out, bus.mem_write_out});
         end
`ifdef EXE_MEM_PERF_EN
         checks++;
         if (stall_cycles !== 32'(exp_stall) || bubble_cycles !== 32'(exp_bubble) || skid_hits !== 16'(exp_skid)) begin
            errors++; $display("FAIL rnd_perf c=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, stall_cycles, bubble_cycles, skid_hits, exp_stall, exp_bubble, exp_skid);
         end
`endif
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      model_reset();
      test_reset();
      test_steady_flow();
      test_freeze_skid();
      test_bubble_gating();
      test_flush_freeze_full();
      test_flush_busy();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
